stream_bank_scheduler: RTL and testbench

STREAM_BANK_SCHEDULER -- requirements
Module: stream_bank_scheduler

---
 rtl/stream_bank_scheduler_if.sv | 40 ++++
 rtl/stream_bank_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_stream_bank_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_bank_scheduler_if.sv
// Bundle for the sample stream input, the two-bank RAM write port and the reader handshake.
// The scheduler connects through the slave modport.
interface stream_bank_scheduler_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tuser;
    logic              s_tlast;
    logic              s_tready;

    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              frame_avail;
    logic              rd_acq;
    logic              rd_rel;
    logic              rd_active;
    logic              rd_bank;
    logic [ADDR_W:0]   rd_len;

    modport master (
        output s_tdata, s_tvalid, s_tuser, s_tlast,
        input  s_tready,
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  frame_avail, rd_active, rd_bank, rd_len,
        output rd_acq, rd_rel
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tuser, s_tlast,
        output s_tready,
        output wr_en, wr_bank, wr_addr, wr_data,
        output frame_avail, rd_active, rd_bank, rd_len,
        input  rd_acq, rd_rel
    );
endinterface

// File: rtl/stream_bank_scheduler.sv
// Captures AXI-Stream frames into a ping-pong pair of sample banks and hands
// completed banks to a reader, oldest first, dropping frames when no bank is free.
module stream_bank_scheduler #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic                    enable,
    input  logic [ADDR_W:0]         frame_len,
    stream_bank_scheduler_if.slave  bus,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1) << ADDR_W;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {W_IDLE, W_SYNC, W_FILL} wstate_e;
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_READY, B_READING} bstate_e;

    wstate_e           wst_q, wst_d;
    bstate_e           bank_q [2];
    bstate_e           bank_d [2];
    logic [LEN_W-1:0]  len_q [2];
    logic [LEN_W-1:0]  len_d [2];
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  flen_q, flen_d;
    logic              fill_bank_q, fill_bank_d;
    logic              pend_q, pend_d;
    logic              pend_bank_q, pend_bank_d;
    logic              age_q, age_d;
    logic [15:0]       drop_q, drop_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              avail_q, avail_d;
    logic              rd_active_q, rd_active_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;

    logic              accept;
    logic [LEN_W-1:0]  flen_eff;
    logic              have_empty;
    logic              claim_bank;
    logic              wr_go;
    logic              tgt;
    logic [LEN_W-1:0]  lim;
    logic [LEN_W-1:0]  addr_n;
    logic [LEN_W-1:0]  cnt_n;
    logic              r0, r1, reading;

    assign accept     = ce & bus.s_tvalid;
    assign flen_eff   = ((frame_len == '0) || (frame_len > DEPTH)) ? DEPTH : frame_len;
    assign have_empty = (bank_q[0] == B_EMPTY) || (bank_q[1] == B_EMPTY);
    assign claim_bank = (bank_q[0] == B_EMPTY) ? 1'b0 : 1'b1;

    // Next-state: writer FSM, bank bookkeeping, reader handshake and reader view.
    always_comb begin
        wst_d       = wst_q;
        bank_d      = bank_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        flen_d      = flen_q;
        fill_bank_d = fill_bank_q;
        pend_d      = 1'b0;
        pend_bank_d = pend_bank_q;
        age_d       = age_q;
        drop_d      = drop_q;
        wr_en_d     = 1'b0;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        avail_d     = avail_q;
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_len_d    = rd_len_q;
        wr_go       = 1'b0;
        tgt         = fill_bank_q;
        lim         = flen_q;
        addr_n      = '0;
        cnt_n       = '0;
        r0          = 1'b0;
        r1          = 1'b0;
        reading     = 1'b0;

        // A finished bank waits one cycle so its last write lands before the reader sees it.
        if (pend_q) begin
            bank_d[pend_bank_q] = B_READY;
        end

        unique case (wst_q)
            W_IDLE: begin
                if (enable) begin
                    wst_d = W_SYNC;
                end
            end
            W_SYNC: begin
                if (!enable) begin
                    wst_d = W_IDLE;
                end else if (accept && bus.s_tuser) begin
                    if (have_empty) begin
                        wr_go               = 1'b1;
                        tgt                 = claim_bank;
                        lim                 = flen_eff;
                        fill_bank_d         = claim_bank;
                        flen_d              = flen_eff;
                        bank_d[claim_bank]  = B_FILLING;
                        wst_d               = W_FILL;
                    end else if (drop_q != DROP_MAX) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    wr_go = 1'b1;
                end
            end
            default: wst_d = W_IDLE;
        endcase

        // A start-of-frame beat always rewinds the fill to address 0.
        if (wr_go) begin
            addr_n    = bus.s_tuser ? '0 : cnt_q;
            cnt_n     = addr_n + LEN_W'(1);
            cnt_d     = cnt_n;
            wr_en_d   = 1'b1;
            wr_bank_d = tgt;
            wr_addr_d = addr_n[ADDR_W-1:0];
            wr_data_d = bus.s_tdata;
            if ((cnt_n == lim) || bus.s_tlast) begin
                len_d[tgt]  = cnt_n;
                pend_d      = 1'b1;
                pend_bank_d = tgt;
                cnt_d       = '0;
                wst_d       = enable ? W_SYNC : W_IDLE;
            end
        end

        // Release wins over acquire; acquire is only possible with no bank being read.
        if (rd_active_q && bus.rd_rel) begin
            bank_d[rd_bank_q] = B_EMPTY;
            rd_active_d       = 1'b0;
        end else if (avail_q && bus.rd_acq) begin
            bank_d[rd_bank_q] = B_READING;
            rd_active_d       = 1'b1;
        end

        r0      = (bank_d[0] == B_READY);
        r1      = (bank_d[1] == B_READY);
        reading = (bank_d[0] == B_READING) || (bank_d[1] == B_READING);
        age_d   = (r0 && !r1) ? 1'b0 : ((r1 && !r0) ? 1'b1 : age_q);
        avail_d = (r0 || r1) && !reading;
        if (avail_d) begin
            rd_bank_d = age_d;
            rd_len_d  = len_d[age_d];
        end
    end

    // State registers; wr_en is a one-cycle strobe so it clears even while ce is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wst_q       <= W_IDLE;
            bank_q[0]   <= B_EMPTY;
            bank_q[1]   <= B_EMPTY;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            cnt_q       <= '0;
            flen_q      <= '0;
            fill_bank_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            age_q       <= 1'b0;
            drop_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            avail_q     <= 1'b0;
            rd_active_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_len_q    <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            if (ce) begin
                wst_q       <= wst_d;
                bank_q      <= bank_d;
                len_q       <= len_d;
                cnt_q       <= cnt_d;
                flen_q      <= flen_d;
                fill_bank_q <= fill_bank_d;
                pend_q      <= pend_d;
                pend_bank_q <= pend_bank_d;
                age_q       <= age_d;
                drop_q      <= drop_d;
                wr_bank_q   <= wr_bank_d;
                wr_addr_q   <= wr_addr_d;
                wr_data_q   <= wr_data_d;
                avail_q     <= avail_d;
                rd_active_q <= rd_active_d;
                rd_bank_q   <= rd_bank_d;
                rd_len_q    <= rd_len_d;
            end
        end
    end

    assign bus.s_tready    = ce;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_bank     = wr_bank_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_avail = avail_q;
    assign bus.rd_active   = rd_active_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.rd_len      = rd_len_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_stream_bank_scheduler.sv
// Bench for stream_bank_scheduler: directed frame scenarios then random traffic,
// with writes and reader status checked against a frame-level reference model.
module tb_stream_bank_scheduler;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ce;
    logic            enable;
    logic [ADDR_W:0] frame_len;
    logic [15:0]     drop_cnt;

    stream_bank_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    stream_bank_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .enable    (enable),
        .frame_len (frame_len),
        .bus       (bus),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  mon_on = 1'b0;

    // Reference model: bank status codes 0 empty, 1 filling, 2 ready, 3 reading.
    int  m_bank[2];
    int  m_len[2];
    int  ready_list[$];
    int  m_pend;
    int  m_ws;
    int  m_cnt, m_lim, m_fb, m_drop, m_rb, m_rl;
    bit  m_avail, m_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode_len(input int fl);
        return (fl == 0 || fl > DEPTH) ? DEPTH : fl;
    endfunction

    task automatic model_reset();
        m_bank[0] = 0; m_bank[1] = 0;
        m_len[0]  = 0; m_len[1]  = 0;
        ready_list.delete();
        m_pend = -1; m_ws = 0; m_cnt = 0; m_lim = 0; m_fb = 0; m_drop = 0;
        m_avail = 0; m_act = 0; m_rb = 0; m_rl = 0;
    endtask

    task automatic take_beat();
        wr_t w;
        int  addr;
        addr   = bus.s_tuser ? 0 : m_cnt;
        w.bank = 1'(m_fb);
        w.addr = ADDR_W'(addr);
        w.data = bus.s_tdata;
        exp_q.push_back(w);
        m_cnt = addr + 1;
        if (m_cnt == m_lim || bus.s_tlast) begin
            m_len[m_fb] = m_cnt;
            m_pend      = m_fb;
            m_ws        = enable ? 1 : 0;
        end
    endtask

    // Applies the inputs held during the cycle that just ended.
    task automatic model_step();
        int  old_pend;
        bit  e0, e1, rd_now;
        int  b;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!ce) return;
        old_pend = m_pend;
        m_pend   = -1;
        e0 = (m_bank[0] == 0);
        e1 = (m_bank[1] == 0);
        case (m_ws)
            0: if (enable) m_ws = 1;
            1: begin
                if (!enable) m_ws = 0;
                else if (bus.s_tvalid && bus.s_tuser) begin
                    if (e0 || e1) begin
                        m_fb = e0 ? 0 : 1;
                        m_bank[m_fb] = 1;
                        m_lim = decode_len(int'(frame_len));
                        m_cnt = 0;
                        m_ws  = 2;
                        take_beat();
                    end else if (m_drop < 65535) m_drop++;
                end
            end
            default: if (bus.s_tvalid) take_beat();
        endcase
        if (m_act && bus.rd_rel) begin
            m_bank[m_rb] = 0;
            m_act = 0;
        end else if (m_avail && bus.rd_acq) begin
            b = ready_list.pop_front();
            m_bank[b] = 3;
            m_act = 1;
            m_rb  = b;
        end
        if (old_pend >= 0) begin
            m_bank[old_pend] = 2;
            ready_list.push_back(old_pend);
        end
        rd_now  = (m_bank[0] == 3) || (m_bank[1] == 3);
        m_avail = (ready_list.size() > 0) && !rd_now;
        if (m_avail) begin
            m_rb = ready_list[0];
            m_rl = m_len[m_rb];
        end
    endtask

    // Monitor: pops one expected write per strobe and compares reader status.
    always @(negedge clk) begin
        wr_t e;
        if (mon_on) begin
            check("wr_en", bus.wr_en, exp_q.size() == 1);
            if (bus.wr_en === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_bank", bus.wr_bank, e.bank);
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
            end
            check("s_tready", bus.s_tready, ce);
            check("frame_avail", bus.frame_avail, m_avail);
            check("rd_active", bus.rd_active, m_act);
            check("rd_bank", bus.rd_bank, m_rb);
            check("rd_len", bus.rd_len, m_rl);
            check("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input bit u, input bit l, input logic [DATA_W-1:0] d);
        bus.s_tvalid = 1'b1; bus.s_tuser = u; bus.s_tlast = l; bus.s_tdata = d;
        tick();
        bus.s_tvalid = 1'b0; bus.s_tuser = 1'b0; bus.s_tlast = 1'b0;
    endtask

    task automatic pulse_acq();
        bus.rd_acq = 1'b1; tick(); bus.rd_acq = 1'b0;
    endtask

    task automatic pulse_rel();
        bus.rd_rel = 1'b1; tick(); bus.rd_rel = 1'b0;
    endtask

    task automatic drain();
        repeat (2) begin
            wait_n(3);
            pulse_acq();
            pulse_rel();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0; ce = 1'b1; enable = 1'b0; frame_len = 5'd4;
        bus.s_tvalid = 1'b0; bus.s_tuser = 1'b0; bus.s_tlast = 1'b0; bus.s_tdata = '0;
        bus.rd_acq = 1'b0; bus.rd_rel = 1'b0;
        tick();
        mon_on = 1'b1;
        tick();
        reset_n = 1'b1;

        // Basic 4-sample frame into bank 0.
        enable = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) send(i == 1, 1'b0, 16'(i));
        wait_n(4);
        @(negedge clk);
        check("basic_rd_len", bus.rd_len, 4);
        check("basic_avail", bus.frame_avail, 1);
        pulse_acq();
        pulse_rel();

        // tlast cuts an 8-sample frame at 3; trailing beats ignored.
        frame_len = 5'd8;
        send(1'b1, 1'b0, 16'h10); send(1'b0, 1'b0, 16'h11); send(1'b0, 1'b1, 16'h12);
        send(1'b0, 1'b0, 16'h13); send(1'b0, 1'b0, 16'h14);
        wait_n(3);
        @(negedge clk);
        check("tlast_rd_len", bus.rd_len, 3);
        pulse_acq();
        pulse_rel();

        // Three frames with no reader: third dropped, bank 0 is oldest.
        do_reset();
        frame_len = 5'd2;
        tick();
        for (int f = 0; f < 3; f++) begin
            send(1'b1, 1'b0, 16'(16 * f));
            send(1'b0, 1'b0, 16'(16 * f + 1));
        end
        wait_n(3);
        @(negedge clk);
        check("three_drop", drop_cnt, 1);
        check("three_oldest", bus.rd_bank, 0);
        pulse_acq();
        @(negedge clk);
        check("acq_bank", bus.rd_bank, 0);
        check("acq_active", bus.rd_active, 1);
        pulse_rel();
        send(1'b1, 1'b0, 16'hA0);
        send(1'b0, 1'b0, 16'hA1);
        drain();

        // Mid-frame restart.
        frame_len = 5'd4;
        send(1'b1, 1'b0, 16'hB0); send(1'b0, 1'b0, 16'hB1);
        for (int i = 0; i < 4; i++) send(i == 0, 1'b0, 16'(16'hC0 + i));
        wait_n(3);
        @(negedge clk);
        check("restart_len", bus.rd_len, 4);
        pulse_acq();
        pulse_rel();

        // ce low mid-frame freezes, then reset with ce low mid-frame.
        frame_len = 5'd8;
        send(1'b1, 1'b0, 16'hD0); send(1'b0, 1'b0, 16'hD1);
        ce = 1'b0; bus.s_tvalid = 1'b1; bus.s_tdata = 16'hDEAD;
        wait_n(3);
        ce = 1'b1; bus.s_tvalid = 1'b0;
        send(1'b0, 1'b0, 16'hD2);
        ce = 1'b0; reset_n = 1'b0; bus.s_tvalid = 1'b1;
        tick();
        reset_n = 1'b1; ce = 1'b1; bus.s_tvalid = 1'b0;
        @(negedge clk);
        check("rst_avail", bus.frame_avail, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_rd_len", bus.rd_len, 0);
        tick();

        // Length boundaries: 0 and over-range clamp to the bank depth, and length 1.
        for (int k = 0; k < 3; k++) begin
            frame_len = (k == 0) ? 5'd0 : ((k == 1) ? 5'd31 : 5'd16);
            for (int i = 0; i < DEPTH + 2; i++) send(i == 0, 1'b0, 16'(256 * k + i));
            wait_n(3);
            pulse_acq();
            pulse_rel();
        end
        frame_len = 5'd1;
        repeat (3) send(1'b1, 1'b0, 16'($urandom));
        wait_n(2);
        @(negedge clk);
        check("len1_drop", drop_cnt, 1);
        drain();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 999) > 2);
            ce      = ($urandom_range(0, 9) != 0);
            enable  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0) frame_len = 5'($urandom_range(0, 31));
            bus.s_tvalid = ($urandom_range(0, 9) < 7);
            bus.s_tuser  = ($urandom_range(0, 9) == 0);
            bus.s_tlast  = ($urandom_range(0, 19) == 0);
            bus.s_tdata  = 16'($urandom);
            bus.rd_acq   = ($urandom_range(0, 4) == 0);
            bus.rd_rel   = ($urandom_range(0, 6) == 0);
            tick();
        end

        reset_n = 1'b1; ce = 1'b1;
        bus.s_tvalid = 1'b0; bus.rd_acq = 1'b0; bus.rd_rel = 1'b0;
        wait_n(3);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
